// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction applied in a single FIX cycle.
module ysyx_24080006_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      mdu_op,
    input  logic            signed_a,
    input  logic            signed_b,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [1:0] OP_MULL = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    state_t state, state_next;

    logic [1:0]        op_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [4:0]        counter;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   divisor;

    logic              accept;
    logic              in_neg_a;
    logic              in_neg_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_result;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] product_signed;
    logic [XLEN-1:0]   fix_result;

    assign accept   = in_valid & in_ready & ~kill;
    assign in_neg_a = signed_a & src_a[XLEN-1];
    assign in_neg_b = signed_b & src_b[XLEN-1];
    assign abs_a    = in_neg_a ? -src_a : src_a;
    assign abs_b    = in_neg_b ? -src_b : src_b;
    assign div_zero = (src_b == '0);
    assign div_ovf  = signed_a & signed_b & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
    assign fast     = mdu_op[1] & (div_zero | div_ovf);

    // Divide-by-zero takes priority; the signed overflow case only applies to a nonzero divisor.
    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            fast_result = (mdu_op == OP_DIV) ? '1 : src_a;
        end else begin
            fast_result = (mdu_op == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        end
    end

    assign rem_shift      = {remainder, quotient[XLEN-1]};
    assign rem_diff       = rem_shift - {1'b0, divisor};
    assign product_signed = (neg_a_q ^ neg_b_q) ? -product : product;

    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MULL: fix_result = product_signed[XLEN-1:0];
            OP_MULH: fix_result = product_signed[2*XLEN-1:XLEN];
            OP_DIV:  fix_result = (neg_a_q ^ neg_b_q) ? -quotient : quotient;
            OP_REM:  fix_result = neg_a_q ? -remainder : remainder;
            default: fix_result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = fast ? DONE : CALC;
                CALC:    if (counter == 5'(XLEN-1)) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: multiply and divide keep separate shift registers, selected by the latched op.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            counter   <= '0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            quotient  <= '0;
            remainder <= '0;
            divisor   <= '0;
            result    <= '0;
        end else if (kill) begin
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= mdu_op;
                        neg_a_q   <= in_neg_a;
                        neg_b_q   <= in_neg_b;
                        counter   <= '0;
                        product   <= '0;
                        mcand     <= {{XLEN{1'b0}}, abs_a};
                        mplier    <= abs_b;
                        quotient  <= abs_a;
                        remainder <= '0;
                        divisor   <= abs_b;
                        if (fast) begin
                            result <= fast_result;
                        end
                    end
                end
                CALC: begin
                    counter <= counter + 5'd1;
                    if (op_q[1]) begin
                        if (!rem_diff[XLEN]) begin
                            remainder <= rem_diff[XLEN-1:0];
                            quotient  <= {quotient[XLEN-2:0], 1'b1};
                        end else begin
                            remainder <= rem_shift[XLEN-1:0];
                            quotient  <= {quotient[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (mplier[0]) begin
                            product <= product + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    result <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Scoreboard bench for the MDU: expected results are queued at accept and popped when out_valid
// rises, with latency, backpressure, kill and mid-operation reset checks.
module tb_ysyx_24080006_mdu;

    logic        clock = 1'b0;
    logic        reset;
    logic        kill;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mdu_op;
    logic        signed_a;
    logic        signed_b;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    typedef struct {
        logic [1:0]  op;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    ysyx_24080006_mdu #(.XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_op    (mdu_op),
        .signed_a  (signed_a),
        .signed_b  (signed_b),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    // Reference built on 64-bit signed arithmetic; division truncates and % follows the dividend.
    function automatic logic [31:0] model(logic [1:0] op, logic sa, logic sb, logic [31:0] a, logic [31:0] b);
        longint av;
        longint bv;
        longint p;
        av = sa ? longint'($signed(a)) : longint'({32'b0, a});
        bv = sb ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 0;
        if (op == 2'd0 || op == 2'd1) begin
            p = av * bv;
            return (op == 2'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        if (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == 2'd2) ? 32'h8000_0000 : 32'h0;
        p = (op == 2'd2) ? (av / bv) : (av % bv);
        return p[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic sa, input logic sb,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        mdu_op   = op;
        signed_a = sa;
        signed_b = sb;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clock);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    // Latency 1 means out_valid is seen in the first cycle after the accepting edge.
    task automatic wait_out(output int lat, output bit timeout);
        lat     = 1;
        timeout = 1'b0;
        while (!out_valid) begin
            if (lat >= 100) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mdu_op    = 2'd0;
        signed_a  = 1'b0;
        signed_b  = 1'b0;
        src_a     = 32'h0;
        src_b     = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
        compared++;
        if (result !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_result got %h want 00000000", result);
        end
        last_res = 32'h0;
    endtask

    task automatic test_directed;
        vec_t        v[13];
        int          lat;
        bit          to;
        logic [31:0] e;
        v[0]  = '{2'd0, 1'b0, 1'b0, 32'd3,        32'd7,        32'd21,        34};
        v[1]  = '{2'd1, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000,  34};
        v[2]  = '{2'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  34};
        v[3]  = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  34};
        v[4]  = '{2'd2, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  34};
        v[5]  = '{2'd3, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  34};
        v[6]  = '{2'd2, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC,  34};
        v[7]  = '{2'd3, 1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,         34};
        v[8]  = '{2'd2, 1'b0, 1'b0, 32'd5,        32'd0,        32'hFFFFFFFF,  1};
        v[9]  = '{2'd3, 1'b0, 1'b0, 32'd5,        32'd0,        32'd5,         1};
        v[10] = '{2'd2, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1};
        v[11] = '{2'd3, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,         1};
        v[12] = '{2'd0, 1'b1, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25,        34};
        for (int i = 0; i < 13; i++) begin
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL dir%0d_ready_before got %b want 1", i, in_ready);
            end
            applyStimulus(v[i].op, v[i].sa, v[i].sb, v[i].a, v[i].b, v[i].e);
            wait_out(lat, to);
            compared++;
            if (to || lat != v[i].lat) begin
                mismatched++;
                $display("[TB] FAIL dir%0d_latency got %0d (timeout=%0b) want %0d", i, lat, to, v[i].lat);
            end
            e = exp_q.pop_front();
            compared++;
            if (result !== e) begin
                mismatched++;
                $display("[TB] FAIL dir%0d_result got %h want %h", i, result, e);
            end
            last_res  = e;
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
            compared++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL dir%0d_release got valid=%b ready=%b want valid=0 ready=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          lat;
        int          want_lat;
        bit          to;
        logic [1:0]  op;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            want_lat = (op[1] && (b == 32'h0 || (sa && sb && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 34;
            applyStimulus(op, sa, sb, a, b, model(op, sa, sb, a, b));
            wait_out(lat, to);
            compared++;
            if (to || lat != want_lat) begin
                mismatched++;
                $display("[TB] FAIL rnd%0d_latency got %0d (timeout=%0b) want %0d", i, lat, to, want_lat);
            end
            e = exp_q.pop_front();
            compared++;
            if (result !== e) begin
                mismatched++;
                $display("[TB] FAIL rnd%0d_result op=%0d sa=%b sb=%b a=%h b=%h got %h want %h",
                         i, op, sa, sb, a, b, result, e);
            end
            last_res  = e;
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int          lat;
        bit          to;
        logic [31:0] e;
        applyStimulus(2'd0, 1'b1, 1'b1, 32'hFFFFFFFD, 32'd1234, 32'hFFFFF18A);
        wait_out(lat, to);
        compared++;
        if (to) begin
            mismatched++;
            $display("[TB] FAIL bp_timeout got no out_valid want out_valid");
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            src_a    = $urandom;
            src_b    = $urandom;
            @(posedge clock);
            #1;
            compared++;
            if (result !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d got result=%h ready=%b valid=%b want result=%h ready=0 valid=1",
                         i, result, in_ready, out_valid, e);
            end
        end
        in_valid  = 1'b0;
        last_res  = e;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    // Aborts a divide at cycle T+10 using kill (use_reset=0) or reset (use_reset=1).
    task automatic abort_divide(input bit use_reset);
        bit seen_valid;
        seen_valid = 1'b0;
        applyStimulus(2'd2, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        if (use_reset) reset = 1'b1;
        else           kill  = 1'b1;
        in_valid = 1'b1;
        mdu_op   = 2'd0;
        src_a    = 32'd9;
        src_b    = 32'd9;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        kill     = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        if (use_reset) last_res = 32'h0;
        compared++;
        if (seen_valid || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort%0d_out_valid got seen=%b now=%b want 0", use_reset, seen_valid, out_valid);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort%0d_in_ready got %b want 1", use_reset, in_ready);
        end
        compared++;
        if (result !== last_res) begin
            mismatched++;
            $display("[TB] FAIL abort%0d_result got %h want %h", use_reset, result, last_res);
        end
    endtask

    task automatic test_kill;
        int          lat;
        bit          to;
        logic [31:0] e;
        abort_divide(1'b0);
        applyStimulus(2'd0, 1'b1, 1'b1, 32'd6, 32'hFFFFFFFB, 32'hFFFFFFE2);
        wait_out(lat, to);
        compared++;
        if (to || lat != 34) begin
            mismatched++;
            $display("[TB] FAIL kill_next_latency got %0d (timeout=%0b) want 34", lat, to);
        end
        e = exp_q.pop_front();
        compared++;
        if (result !== e) begin
            mismatched++;
            $display("[TB] FAIL kill_next_result got %h want %h", result, e);
        end
        last_res  = e;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        abort_divide(1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
